// File: rtl/nvram_upload_responder_if.sv
// hps_io ioctl upload channel as seen by the NVRAM upload responder.
// master = hps_io side, slave = responder side.
interface nvram_upload_responder_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload,
        output ioctl_index,
        output ioctl_rd,
        output ioctl_addr,
        input  ioctl_din,
        input  ioctl_wait
    );

    modport slave (
        input  ioctl_upload,
        input  ioctl_index,
        input  ioctl_rd,
        input  ioctl_addr,
        output ioctl_din,
        output ioctl_wait
    );
endinterface

// File: rtl/nvram_upload_responder.sv
// Serves NVRAM bytes to hps_io over the ioctl upload channel while holding the CPU paused.
// Define NVRAM_UPLOAD_CHECKSUM_EN to return a balancing checksum byte at address DEPTH.
module nvram_upload_responder #(
    parameter int unsigned ADDR_W        = 8,
    parameter logic [7:0]  UPLOAD_INDEX  = 8'd4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nvram_upload_responder_if.slave ioctl,
    output logic                   pause_req,
    output logic [ADDR_W-1:0]      ram_addr,
    input  logic [7:0]             ram_q,
    output logic                   busy,
    output logic                   done
);

    localparam logic [24:0] DepthA = 25'd1 << ADDR_W;
    localparam int unsigned CntW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSettle, StReady, StFetch, StPresent} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [7:0]        din_q;
    logic              wait_q;
    logic              pend_q;
    logic [24:0]       pend_addr_q;
    logic              fetched_q;

    logic        sel;
    logic        req_valid;
    logic [24:0] req_addr;
    logic        in_range;
    logic        dispatch;
    logic [7:0]  oor_byte;

    assign sel       = ioctl.ioctl_upload && (ioctl.ioctl_index == UPLOAD_INDEX);
    // A strobe latched during SETTLE takes priority over the live bus.
    assign req_valid = pend_q || ioctl.ioctl_rd;
    assign req_addr  = pend_q ? pend_addr_q : ioctl.ioctl_addr;
    assign in_range  = req_addr < DepthA;
    assign dispatch  = ((state_q == StSettle) && (cnt_q == '0) && req_valid) ||
                       ((state_q == StReady) && ioctl.ioctl_rd);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q;
    assign oor_byte = (req_addr == DepthA) ? (8'd0 - sum_q) : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif

    assign ioctl.ioctl_din  = din_q;
    assign ioctl.ioctl_wait = wait_q;
    assign busy             = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            din_q       <= 8'h00;
            wait_q      <= 1'b0;
            pause_req   <= 1'b0;
            ram_addr    <= '0;
            done        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            fetched_q   <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            if ((state_q != StIdle) && !sel) begin
                // Session end aborts whatever is in flight.
                state_q   <= StIdle;
                wait_q    <= 1'b0;
                pause_req <= 1'b0;
                done      <= 1'b1;
                pend_q    <= 1'b0;
                fetched_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (sel) begin
                            state_q   <= StSettle;
                            pause_req <= 1'b1;
                            wait_q    <= 1'b1;
                            cnt_q     <= CntLoad;
                            pend_q    <= 1'b0;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                            sum_q     <= 8'h00;
`endif
                        end
                    end
                    StSettle: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CntW'(1);
                            if (ioctl.ioctl_rd && !pend_q) begin
                                pend_q      <= 1'b1;
                                pend_addr_q <= ioctl.ioctl_addr;
                            end
                        end else if (!req_valid) begin
                            state_q <= StReady;
                            wait_q  <= 1'b0;
                        end
                    end
                    StReady: ;
                    StFetch: state_q <= StPresent;
                    StPresent: begin
                        if (fetched_q) begin
                            din_q <= ram_q;
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                            sum_q <= sum_q + ram_q;
`endif
                        end
                        wait_q  <= 1'b0;
                        state_q <= StReady;
                    end
                    default: state_q <= StIdle;
                endcase

                if (dispatch) begin
                    wait_q <= 1'b1;
                    pend_q <= 1'b0;
                    if (in_range) begin
                        ram_addr  <= req_addr[ADDR_W-1:0];
                        fetched_q <= 1'b1;
                        state_q   <= StFetch;
                    end else begin
                        din_q     <= oor_byte;
                        fetched_q <= 1'b0;
                        state_q   <= StPresent;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nvram_upload_responder.sv
// Directed bench for nvram_upload_responder; NVRAM modelled as a registered byte RAM.
module tb_nvram_upload_responder;

    logic       clk;
    logic       reset_n;
    logic       pause_req;
    logic [7:0] ram_addr;
    logic [7:0] ram_q;
    logic       busy;
    logic       done;
    logic [7:0] mem [0:255];

    int n_assert;
    int n_fail;
    int n;
    int lat;

    nvram_upload_responder_if ioctl_bus ();

    nvram_upload_responder #(
        .ADDR_W       (8),
        .UPLOAD_INDEX (8'd4),
        .SETTLE_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ioctl    (ioctl_bus),
        .pause_req(pause_req),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_din"}, ioctl_bus.ioctl_din, 32'h00);
        check({tag, "_wait"}, ioctl_bus.ioctl_wait, 32'h0);
        check({tag, "_pause"}, pause_req, 32'h0);
        check({tag, "_ram_addr"}, ram_addr, 32'h00);
        check({tag, "_busy"}, busy, 32'h0);
        check({tag, "_done"}, done, 32'h0);
    endtask

    // Counts negedge samples with ioctl_wait high, bounded by limit.
    task automatic wait_low(input int limit, output int cnt);
        cnt = 0;
        while (ioctl_bus.ioctl_wait && cnt < limit) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; returns clocks from strobe until ioctl_wait is low again.
    task automatic do_read(input logic [24:0] a, output int l);
        ioctl_bus.ioctl_rd   = 1'b1;
        ioctl_bus.ioctl_addr = a;
        @(negedge clk);
        ioctl_bus.ioctl_rd = 1'b0;
        l = 1;
        while (ioctl_bus.ioctl_wait && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        ioctl_bus.ioctl_upload = 1'b0;
        ioctl_bus.ioctl_index  = 8'd0;
        ioctl_bus.ioctl_rd     = 1'b0;
        ioctl_bus.ioctl_addr   = 25'd0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
        mem[16] = 8'hA5;

        #1 reset_n = 1'b0;
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reads with sel low are ignored: no upload, then wrong index.
        ioctl_bus.ioctl_index = 8'd4;
        ioctl_bus.ioctl_addr  = 25'd5;
        ioctl_bus.ioctl_rd    = 1'b1;
        @(negedge clk);
        ioctl_bus.ioctl_rd     = 1'b0;
        ioctl_bus.ioctl_upload = 1'b1;
        ioctl_bus.ioctl_index  = 8'd3;
        ioctl_bus.ioctl_rd     = 1'b1;
        @(negedge clk);
        ioctl_bus.ioctl_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_din", ioctl_bus.ioctl_din, 32'h00);
        check("idle_pause", pause_req, 32'h0);
        check("idle_busy", busy, 32'h0);
        check("idle_wait", ioctl_bus.ioctl_wait, 32'h0);

        // Settle window and first in-range read.
        ioctl_bus.ioctl_index = 8'd4;
        @(negedge clk);
        check("settle_pause", pause_req, 32'h1);
        check("settle_busy", busy, 32'h1);
        wait_low(40, n);
        check("settle_len", n, 32'd16);
        check("ready_pause", pause_req, 32'h1);
        do_read(25'h10, lat);
        check("rd10_lat", lat, 32'd3);
        check("rd10_din", ioctl_bus.ioctl_din, 32'hA5);
        check("rd10_ram_addr", ram_addr, 32'h10);

        // Out-of-range reads.
        do_read(25'd256, lat);
        check("oor256_lat", lat, 32'd2);
        check("oor256_din", ioctl_bus.ioctl_din, 32'hFF);
        check("oor256_ram_addr", ram_addr, 32'h10);
        do_read(25'h1FFFFFF, lat);
        check("oormax_lat", lat, 32'd2);
        check("oormax_din", ioctl_bus.ioctl_din, 32'hFF);
        check("oormax_ram_addr", ram_addr, 32'h10);

        // Strobe held while wait is high must not disturb the in-flight byte.
        ioctl_bus.ioctl_rd   = 1'b1;
        ioctl_bus.ioctl_addr = 25'h20;
        @(negedge clk);
        ioctl_bus.ioctl_addr = 25'h30;
        @(negedge clk);
        ioctl_bus.ioctl_rd = 1'b0;
        wait_low(10, n);
        check("viol_din", ioctl_bus.ioctl_din, 32'h1C);
        check("viol_ram_addr", ram_addr, 32'h20);

        // Full dump of the RAM.
        mem[16] = 8'h2C;
        for (int a = 0; a < 256; a++) begin
            do_read(25'(a), lat);
            check("dump_din", ioctl_bus.ioctl_din, 32'(8'(a) ^ 8'h3C));
            check("dump_lat", lat, 32'd3);
        end
        ioctl_bus.ioctl_upload = 1'b0;
        @(negedge clk);
        check("end_done", done, 32'h1);
        check("end_pause", pause_req, 32'h0);
        check("end_wait", ioctl_bus.ioctl_wait, 32'h0);
        check("end_busy", busy, 32'h0);
        @(negedge clk);
        check("end_done_clr", done, 32'h0);

        // Abort during FETCH.
        ioctl_bus.ioctl_upload = 1'b1;
        @(negedge clk);
        wait_low(40, n);
        check("abort_settle_len", n, 32'd16);
        ioctl_bus.ioctl_rd   = 1'b1;
        ioctl_bus.ioctl_addr = 25'd3;
        @(negedge clk);
        ioctl_bus.ioctl_rd     = 1'b0;
        ioctl_bus.ioctl_upload = 1'b0;
        @(negedge clk);
        check("abort_wait", ioctl_bus.ioctl_wait, 32'h0);
        check("abort_pause", pause_req, 32'h0);
        check("abort_done", done, 32'h1);
        check("abort_busy", busy, 32'h0);
        check("abort_din", ioctl_bus.ioctl_din, 32'hC3);
        @(negedge clk);
        check("abort_done_clr", done, 32'h0);

        // Index change with upload held ends the session.
        ioctl_bus.ioctl_upload = 1'b1;
        @(negedge clk);
        wait_low(40, n);
        ioctl_bus.ioctl_index = 8'd5;
        @(negedge clk);
        check("idx_done", done, 32'h1);
        check("idx_pause", pause_req, 32'h0);
        ioctl_bus.ioctl_upload = 1'b0;
        ioctl_bus.ioctl_index  = 8'd4;
        @(negedge clk);

        // Strobe during SETTLE is latched and served once settle completes.
        ioctl_bus.ioctl_upload = 1'b1;
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ioctl_bus.ioctl_wait) break;
            n++;
            ioctl_bus.ioctl_rd   = (n == 3);
            ioctl_bus.ioctl_addr = 25'h40;
            @(negedge clk);
        end
        ioctl_bus.ioctl_rd = 1'b0;
        check("latch_wait_len", n, 32'd18);
        check("latch_din", ioctl_bus.ioctl_din, 32'h7C);
        ioctl_bus.ioctl_upload = 1'b0;
        @(negedge clk);
        check("latch_done", done, 32'h1);
        @(negedge clk);

        // Reset in the middle of SETTLE.
        ioctl_bus.ioctl_upload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        check("midrst_done_held", done, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerun_busy", busy, 32'h1);
        check("rerun_pause", pause_req, 32'h1);
        check("rerun_wait", ioctl_bus.ioctl_wait, 32'h1);
        check("rerun_done", done, 32'h0);
        ioctl_bus.ioctl_upload = 1'b0;
        @(negedge clk);
        check("rerun_end_done", done, 32'h1);
        @(negedge clk);

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
        // Checksum byte balances a dump of all-ones.
        for (int a = 0; a < 256; a++) mem[a] = 8'h01;
        ioctl_bus.ioctl_upload = 1'b1;
        @(negedge clk);
        wait_low(40, n);
        for (int a = 0; a < 256; a++) do_read(25'(a), lat);
        do_read(25'd256, lat);
        check("csum_din", ioctl_bus.ioctl_din, 32'h00);
        check("csum_lat", lat, 32'd2);
        do_read(25'd257, lat);
        check("csum_above_din", ioctl_bus.ioctl_din, 32'hFF);
        ioctl_bus.ioctl_upload = 1'b0;
        @(negedge clk);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
